// File: rtl/prbs_checker_pkg.sv
// rtl/prbs_checker_pkg.sv - shared PRBS constants, tap mapping and checker state type
package prbs_checker_pkg;

    localparam int DEF_LOCK_COUNT = 64;
    localparam int DEF_WINDOW     = 1024;
    localparam int DEF_ERR_THRESH = 16;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_t;

    // Second feedback tap for x^POLY + x^T + 1; 0 flags an unsupported polynomial.
    function automatic int prbs_tap(input int poly);
        case (poly)
            7:       return 6;
            23:      return 18;
            31:      return 28;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/prbs_checker_lfsr_step.sv
// rtl/prbs_checker_lfsr_step.sv - combinational next PRBS bit from the shift register
module prbs_lfsr_step
    import prbs_checker_pkg::*;
#(
    parameter int POLY = 7
) (
    input  logic [POLY-1:0] i_sr,
    output logic            o_p
);

    localparam int TAP   = prbs_tap(POLY);
    localparam int TAP_I = (TAP == 0) ? 1 : TAP;

    if (TAP == 0) begin : g_bad_poly
        $error("prbs_lfsr_step: unsupported POLY %0d", POLY);
    end

    assign o_p = i_sr[POLY-1] ^ i_sr[TAP_I-1];

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS checker; PRBS_CHK_POLARITY_EN adds inverted-stream lock
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int POLY       = 7,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int ERR_THRESH = DEF_ERR_THRESH,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
`ifdef PRBS_CHK_POLARITY_EN
    output logic             inverted,
`endif
    output logic             lock_lost
);

    localparam int FW = $clog2(POLY + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    chk_state_t       r_state, w_state_nxt;
    logic [POLY-1:0]  r_sr, w_sr_nxt;
    logic [FW-1:0]    r_fill, w_fill_nxt;
    logic [MW-1:0]    r_match, w_match_nxt, w_match_inc;
    logic [BW-1:0]    r_win_bits, w_win_bits_nxt, w_win_bits_inc;
    logic [EW-1:0]    r_win_err, w_win_err_nxt, w_win_err_inc;
    logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
    logic [CNT_W-1:0] r_bit_count, w_bit_count_nxt;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic             r_lock_lost, w_lock_lost_nxt;
    logic             w_p, w_exp, w_err, w_sr_nz, w_inv;

`ifdef PRBS_CHK_POLARITY_EN
    logic             r_inv, w_inv_nxt;
    logic [MW-1:0]    r_match_i, w_match_i_nxt, w_match_i_inc;
    assign w_inv         = r_inv;
    assign inverted      = r_inv;
    assign w_match_i_inc = r_match_i + 1'b1;
`else
    assign w_inv = 1'b0;
`endif

    prbs_lfsr_step #(.POLY(POLY)) u_step (
        .i_sr (r_sr),
        .o_p  (w_p)
    );

    assign w_exp          = w_p ^ w_inv;
    assign w_err          = in_bit ^ w_exp;
    assign w_sr_nz        = |r_sr;
    assign w_match_inc    = r_match + 1'b1;
    assign w_win_bits_inc = r_win_bits + 1'b1;
    assign w_win_err_inc  = r_win_err + EW'(w_err);

    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_fill_nxt      = r_fill;
        w_match_nxt     = r_match;
        w_win_bits_nxt  = r_win_bits;
        w_win_err_nxt   = r_win_err;
        w_err_count_nxt = r_err_count;
        w_bit_count_nxt = r_bit_count;
        w_lock_lost_nxt = r_lock_lost;
        w_err_pulse_nxt = 1'b0;
`ifdef PRBS_CHK_POLARITY_EN
        w_inv_nxt       = r_inv;
        w_match_i_nxt   = r_match_i;
`endif
        if (in_valid) begin
            if (r_state == ST_SEARCH) begin
                w_sr_nxt = {r_sr[POLY-2:0], in_bit};
                if (r_fill != FW'(POLY)) begin
                    w_fill_nxt = r_fill + 1'b1;
                end else begin
                    w_match_nxt = (!w_err && w_sr_nz) ? w_match_inc : '0;
`ifdef PRBS_CHK_POLARITY_EN
                    w_match_i_nxt = (w_err && w_sr_nz) ? w_match_i_inc : '0;
                    // Normal polarity wins a tie.
                    if (!w_err && w_sr_nz && w_match_inc == MW'(LOCK_COUNT)) begin
                        w_state_nxt = ST_LOCKED;
                        w_inv_nxt   = 1'b0;
                    end else if (w_err && w_sr_nz && w_match_i_inc == MW'(LOCK_COUNT)) begin
                        w_state_nxt = ST_LOCKED;
                        w_inv_nxt   = 1'b1;
                    end
`else
                    if (!w_err && w_sr_nz && w_match_inc == MW'(LOCK_COUNT)) begin
                        w_state_nxt = ST_LOCKED;
                    end
`endif
                end
            end else begin
                // Free-running reference: a line error never enters the shift register.
                w_sr_nxt        = {r_sr[POLY-2:0], w_exp};
                w_err_pulse_nxt = w_err;
                if (r_bit_count != '1) begin
                    w_bit_count_nxt = r_bit_count + 1'b1;
                end
                if (w_err && r_err_count != '1) begin
                    w_err_count_nxt = r_err_count + 1'b1;
                end
                if (w_win_err_inc == EW'(ERR_THRESH)) begin
                    w_state_nxt     = ST_SEARCH;
                    w_lock_lost_nxt = 1'b1;
                    w_fill_nxt      = '0;
                    w_match_nxt     = '0;
                    w_win_bits_nxt  = '0;
                    w_win_err_nxt   = '0;
`ifdef PRBS_CHK_POLARITY_EN
                    w_match_i_nxt   = '0;
`endif
                end else if (w_win_bits_inc == BW'(WINDOW)) begin
                    w_win_bits_nxt = '0;
                    w_win_err_nxt  = '0;
                end else begin
                    w_win_bits_nxt = w_win_bits_inc;
                    w_win_err_nxt  = w_win_err_inc;
                end
            end
        end
        if (clr_cnt) begin
            w_err_count_nxt = '0;
            w_bit_count_nxt = '0;
            w_lock_lost_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win_bits  <= '0;
            r_win_err   <= '0;
            r_err_count <= '0;
            r_bit_count <= '0;
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
`ifdef PRBS_CHK_POLARITY_EN
            r_inv       <= 1'b0;
            r_match_i   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_fill      <= w_fill_nxt;
            r_match     <= w_match_nxt;
            r_win_bits  <= w_win_bits_nxt;
            r_win_err   <= w_win_err_nxt;
            r_err_count <= w_err_count_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_lock_lost <= w_lock_lost_nxt;
`ifdef PRBS_CHK_POLARITY_EN
            r_inv       <= w_inv_nxt;
            r_match_i   <= w_match_i_nxt;
`endif
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;
    assign lock_lost = r_lock_lost;

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Serial PRBS pattern checker: the receive end of the PRBS7/PRBS23/PRBS31 generators used for link and datapath bring-up. Self-synchronises to an incoming pattern bit stream, declares lock, then runs a free-running reference LFSR and counts bit errors. Loss of lock is declared on excessive error density, after which it re-searches. Sits after the deserialiser or loopback point in link-test harnesses.

Parameters:
POLY, 7, pattern select: 7 = x^7+x^6+1, 23 = x^23+x^18+1, 31 = x^31+x^28+1; any other value is an elaboration error
LOCK_COUNT, 64, consecutive correct predictions required to declare lock
WINDOW, 1024, bit window length for loss-of-lock error density
ERR_THRESH, 16, errors within one window that force loss of lock
CNT_W, 32, width of err_count and bit_count

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  in_bit qualifier; no state changes when low
in_bit  in  1  received pattern bit, oldest first
clr_cnt  in  1  clears err_count, bit_count, lock_lost
locked  out  1  checker in LOCKED state
err_pulse  out  1  one-cycle pulse per errored bit while locked
err_count  out  CNT_W  saturating error count while locked
bit_count  out  CNT_W  saturating count of bits checked while locked
lock_lost  out  1  sticky; set on each LOCKED->SEARCH transition

Behaviour:
- Reset value of all outputs is 0; state SEARCH; shift register sr[N-1:0] (N = POLY) zero; all internal counters zero. Reset mid-stream drops lock immediately.
- Tap index T = 6/18/28 for POLY 7/23/31; predicted bit p = sr[N-1] ^ sr[T-1].
- All outputs are registered: the effect of a valid bit is visible the cycle after it is sampled.
- SEARCH, per valid bit: sr <= {sr[N-2:0], in_bit}; fill_cnt increments to N and holds. Once fill_cnt == N: if in_bit == p and sr != 0, match_cnt++; otherwise match_cnt <= 0. The sr != 0 guard keeps a stuck-at-0 line from locking. The match that brings match_cnt to LOCK_COUNT moves the state to LOCKED; locked = 1 the next cycle.
- Lock latency with a clean stream: exactly N + LOCK_COUNT valid bits after reset or loss of lock.
- LOCKED, per valid bit: sr <= {sr[N-2:0], p}. The reference runs free, so one line error counts once, not three times. bit_count++ (saturate at all-ones).
- On in_bit != p in LOCKED: err_pulse = 1 for one cycle; err_count++ (saturate at all-ones); win_err++.
- win_bits counts valid bits in LOCKED. When it reaches WINDOW, both win_bits and win_err clear.
- When win_err reaches ERR_THRESH, the state goes to SEARCH the next cycle: locked = 0, lock_lost = 1, fill_cnt/match_cnt/window counters cleared, sr kept. The threshold check uses the post-increment value and overrides a window rollover in the same bit.
- clr_cnt has priority over a same-cycle increment: counters go to 0, and the coincident error is not counted (err_pulse still fires). clr_cnt does not affect lock state.
- in_valid low: sr, counters and state hold; err_pulse = 0.

Optional Feature:
PRBS_CHK_POLARITY_EN
- Defined: SEARCH tracks a second match counter for the inverted relation in_bit == ~p. Whichever counter reaches LOCK_COUNT first wins; a tie resolves to normal polarity. The winning polarity is latched into an added output port `inverted` (1 bit, reset 0). In LOCKED the comparison is against p ^ inverted.
- Undefined: only true polarity locks; the `inverted` port is absent.

Decomposition:
- Shared package: POLY-to-tap mapping function, state enum (SEARCH, LOCKED), default constants for LOCK_COUNT/WINDOW/ERR_THRESH. The same package is reused by the generators.
- One sub-module, `prbs_lfsr_step`: combinational next-bit p from sr for a given POLY, shared with the generator side.

Test Plan:
1. PRBS7 generator, seed 7'b1010101, continuous valid -> locked rises after exactly 7+64 bits; after 1000 further bits err_count = 0 and bit_count = 1000.
2. After lock, invert one bit -> err_pulse high exactly one cycle, err_count = 1 (not 3), locked stays 1.
3. After lock, inject 16 single-bit errors within 500 bits -> locked falls after the 16th, lock_lost = 1; relock 7+64 clean bits later with lock_lost still 1.
4. Constant-0 input for 10000 bits -> locked never asserts.
5. PRBS31 with in_valid asserted 1 cycle in 3 -> lock after 31+64 valid bits; in-gap cycles change nothing.
6. clr_cnt coincident with an injected error -> err_count = 0, err_pulse = 1. With PRBS_CHK_POLARITY_EN, an inverted PRBS23 stream -> locked = 1, inverted = 1, err_count = 0.
